// File: rtl/sextium_wait_memory.sv
// Simulated Sextium memory and I/O endpoint: wait-stated mem/io accesses with a ready pulse,
// plus first-word-fall-through input and output FIFOs shared with the host.
module sextium_wait_memory #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  input  logic              in_push,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_full,
  input  logic              out_pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_empty
);

  localparam int unsigned MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CW = FIFO_AW + 1;
  localparam int unsigned CMP_W   = ADDR_W + 1;
  localparam int unsigned OP_MR   = 3;
  localparam int unsigned OP_MW   = 2;
  localparam int unsigned OP_IR   = 1;
  localparam int unsigned OP_IW   = 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [3:0]          r_op;
  logic                r_multi;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_err;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   r_in_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  r_in_wr;
  logic [FIFO_AW-1:0]  r_in_rd;
  logic [FIFO_CW-1:0]  r_in_cnt;
  logic [DATA_W-1:0]   r_out_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  r_out_wr;
  logic [FIFO_AW-1:0]  r_out_rd;
  logic [FIFO_CW-1:0]  r_out_cnt;

  logic [3:0]          w_strobes;
  logic                w_multi;
  logic                w_addr_ok;
  logic                w_illegal;
  logic                w_in_empty;
  logic                w_out_full;
  logic                w_host_push;
  logic                w_host_pop;
  logic                w_core_pop;
  logic                w_core_push;
  logic                w_mem_we;
  logic                w_stall;
  logic                w_exec;
  logic                w_do;
  logic [MEM_AW-1:0]   w_mem_idx;

  assign w_strobes   = {mem_read, mem_write, io_read, io_write};
  assign w_multi     = (w_strobes & (w_strobes - 4'd1)) != 4'd0;
  assign w_addr_ok   = {1'b0, r_addr} < CMP_W'(DEPTH);
  assign w_illegal   = r_multi | ((r_op[OP_MR] | r_op[OP_MW]) & ~w_addr_ok);
  assign w_mem_idx   = r_addr[MEM_AW-1:0];

  assign w_in_empty  = (r_in_cnt == '0);
  assign in_full     = (r_in_cnt == FIFO_CW'(FIFO_DEPTH));
  assign out_empty   = (r_out_cnt == '0);
  assign w_out_full  = (r_out_cnt == FIFO_CW'(FIFO_DEPTH));
  assign out_data    = r_out_mem[r_out_rd];

  // A host pop frees the slot a stalled io_write needs in the same edge.
  assign w_host_pop  = out_pop & ~out_empty;
  assign w_stall     = ~w_illegal & ((r_op[OP_IR] & w_in_empty) |
                                     (r_op[OP_IW] & w_out_full & ~w_host_pop));
  assign w_do        = w_exec & ~w_illegal;
  assign w_core_pop  = w_do & r_op[OP_IR];
  assign w_core_push = w_do & r_op[OP_IW];
  assign w_mem_we    = w_do & r_op[OP_MW];
  assign w_host_push = in_push & (~in_full | w_core_pop);

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_exec       = 1'b0;
    case (r_state)
      S_IDLE: if (|w_strobes) w_next_state = S_WAIT;
      S_WAIT: begin
        if (r_cnt == 4'd0 && !w_stall) begin
          w_exec       = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Access latch, wait counter and registered response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_multi <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_exec;
      if (r_state == S_IDLE && |w_strobes) begin
        r_op    <= w_strobes;
        r_multi <= w_multi;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec) begin
        r_err <= w_illegal;
        if (w_illegal)        r_rdata <= '0;
        else if (r_op[OP_MR]) r_rdata <= r_mem[w_mem_idx];
        else if (r_op[OP_IR]) r_rdata <= r_in_mem[r_in_rd];
        else                  r_rdata <= '0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_idx] <= r_wdata;
  end

  always_ff @(posedge clock) begin
    if (w_host_push) r_in_mem[r_in_wr] <= in_data;
    if (w_core_push) r_out_mem[r_out_wr] <= r_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_wr   <= '0;
      r_in_rd   <= '0;
      r_in_cnt  <= '0;
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_host_push) r_in_wr  <= r_in_wr + FIFO_AW'(1);
      if (w_core_pop)  r_in_rd  <= r_in_rd + FIFO_AW'(1);
      r_in_cnt <= r_in_cnt + FIFO_CW'(w_host_push) - FIFO_CW'(w_core_pop);
      if (w_core_push) r_out_wr <= r_out_wr + FIFO_AW'(1);
      if (w_host_pop)  r_out_rd <= r_out_rd + FIFO_AW'(1);
      r_out_cnt <= r_out_cnt + FIFO_CW'(w_core_push) - FIFO_CW'(w_host_pop);
    end
  end

endmodule

// File: tb/tb_sextium_wait_memory.sv
// Scoreboard bench for sextium_wait_memory: LATENCY=2 instance for the main scenarios,
// LATENCY=0 instance for the illegal-address cases.
module tb_sextium_wait_memory;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  logic clock, reset;
  int   cyc, errors, checks;
  exp_t aq[$];
  exp_t bq[$];

  logic        a_mr, a_mw, a_ir, a_iw, a_ready, a_err, a_in_push, a_in_full, a_out_pop, a_out_empty;
  logic [15:0] a_addr, a_wdata, a_rdata, a_in_data, a_out_data;
  logic        b_mr, b_mw, b_ir, b_iw, b_ready, b_err, b_in_full, b_out_empty;
  logic [15:0] b_addr, b_wdata, b_rdata, b_out_data;
  logic        b_in_push, b_out_pop;
  logic [15:0] b_in_data;

  sextium_wait_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(2), .FIFO_DEPTH(8)) u_a (
    .clock(clock), .reset(reset), .mem_read(a_mr), .mem_write(a_mw), .io_read(a_ir), .io_write(a_iw),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .err(a_err),
    .in_push(a_in_push), .in_data(a_in_data), .in_full(a_in_full),
    .out_pop(a_out_pop), .out_data(a_out_data), .out_empty(a_out_empty));

  sextium_wait_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(0), .FIFO_DEPTH(8)) u_b (
    .clock(clock), .reset(reset), .mem_read(b_mr), .mem_write(b_mw), .io_read(b_ir), .io_write(b_iw),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .err(b_err),
    .in_push(b_in_push), .in_data(b_in_data), .in_full(b_in_full),
    .out_pop(b_out_pop), .out_data(b_out_data), .out_empty(b_out_empty));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected response whenever a DUT presents ready.
  always @(negedge clock) begin : mon_a
    exp_t e;
    if (!reset && a_ready) begin
      if (aq.size() == 0) begin
        errors++; checks++;
        $display("FAIL a_unexpected_ready: got ready=1 required no pending access");
      end else begin
        e = aq.pop_front();
        chk("a_rdata", a_rdata, e.rdata);
        chk("a_err", a_err, e.err);
        if (e.lat >= 0) chk("a_latency", cyc + 1 - e.issue, e.lat);
      end
    end
  end

  always @(negedge clock) begin : mon_b
    exp_t e;
    if (!reset && b_ready) begin
      if (bq.size() == 0) begin
        errors++; checks++;
        $display("FAIL b_unexpected_ready: got ready=1 required no pending access");
      end else begin
        e = bq.pop_front();
        chk("b_rdata", b_rdata, e.rdata);
        chk("b_err", b_err, e.err);
        chk("b_latency", cyc + 1 - e.issue, e.lat);
      end
    end
  end

  task automatic a_start(input logic [3:0] s, input logic [15:0] ad, input logic [15:0] wd,
                         input logic [15:0] er, input logic ee, input int lat);
    @(negedge clock);
    {a_mr, a_mw, a_ir, a_iw} = s;
    a_addr  = ad;
    a_wdata = wd;
    aq.push_back('{er, ee, lat, cyc + 1});
  endtask

  task automatic a_wait(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clock);
      a_in_push = 1'b0;
      a_out_pop = 1'b0;
      if (a_ready) done = 1'b1;
    end
    {a_mr, a_mw, a_ir, a_iw} = 4'b0000;
    if (!done) begin
      errors++; checks++;
      $display("FAIL a_timeout: got no ready within %0d cycles required ready", bound);
      aq.delete();
    end
  endtask

  task automatic b_acc(input logic [3:0] s, input logic [15:0] ad, input logic [15:0] wd,
                       input logic [15:0] er, input logic ee);
    bit done = 1'b0;
    @(negedge clock);
    {b_mr, b_mw, b_ir, b_iw} = s;
    b_addr  = ad;
    b_wdata = wd;
    bq.push_back('{er, ee, 2, cyc + 1});
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clock);
      if (b_ready) done = 1'b1;
    end
    {b_mr, b_mw, b_ir, b_iw} = 4'b0000;
    if (!done) begin
      errors++; checks++;
      $display("FAIL b_timeout: got no ready required ready within 8 cycles");
      bq.delete();
    end
  endtask

  initial begin
    bit seen;
    cyc = 0; errors = 0; checks = 0;
    reset = 1'b1;
    {a_mr, a_mw, a_ir, a_iw} = 4'b0000;
    {b_mr, b_mw, b_ir, b_iw} = 4'b0000;
    a_addr = '0; a_wdata = '0; a_in_push = 1'b0; a_in_data = '0; a_out_pop = 1'b0;
    b_addr = '0; b_wdata = '0; b_in_push = 1'b0; b_in_data = '0; b_out_pop = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_ready", a_ready, 0);
    chk("reset_err", a_err, 0);
    chk("reset_rdata", a_rdata, 0);
    chk("reset_in_full", a_in_full, 0);
    chk("reset_out_empty", a_out_empty, 1);

    // Basic memory write/read and top-address boundary.
    a_start(4'b0100, 16'd5, 16'hBEEF, 16'h0000, 1'b0, 4); a_wait(8);
    a_start(4'b1000, 16'd5, 16'h0000, 16'hBEEF, 1'b0, 4); a_wait(8);
    a_start(4'b0100, 16'd3, 16'h5555, 16'h0000, 1'b0, 4); a_wait(8);
    a_start(4'b0100, 16'd1023, 16'hABCD, 16'h0000, 1'b0, 4); a_wait(8);
    a_start(4'b1000, 16'd1023, 16'h0000, 16'hABCD, 1'b0, 4); a_wait(8);
    a_start(4'b1000, 16'd1024, 16'h0000, 16'h0000, 1'b1, 4); a_wait(8);

    // Input FIFO: nine pushes, the ninth is dropped; eight reads in order.
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      a_in_push = 1'b1;
      a_in_data = 16'(32'hC000 + i);
    end
    @(negedge clock);
    a_in_push = 1'b0;
    chk("in_full_after_fill", a_in_full, 1);
    for (int i = 0; i < 8; i++) begin
      a_start(4'b0010, 16'd0, 16'h0000, 16'(32'hC000 + i), 1'b0, 4); a_wait(8);
    end
    chk("in_full_after_drain", a_in_full, 0);

    // io_read stalls on an empty FIFO until the host pushes.
    a_start(4'b0010, 16'd0, 16'h0000, 16'h0042, 1'b0, -1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (a_ready) seen = 1'b1;
    end
    chk("io_read_stall_no_ready", seen, 0);
    @(negedge clock);
    a_in_push = 1'b1;
    a_in_data = 16'h0042;
    a_wait(2);

    // Output FIFO: eight writes fill it, the ninth stalls until one host pop.
    for (int i = 0; i < 8; i++) begin
      a_start(4'b0001, 16'd0, 16'(32'hA000 + i), 16'h0000, 1'b0, 4); a_wait(8);
    end
    a_start(4'b0001, 16'd0, 16'hA008, 16'h0000, 1'b0, -1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (a_ready) seen = 1'b1;
    end
    chk("io_write_stall_no_ready", seen, 0);
    @(negedge clock);
    chk("drain_word_0", a_out_data, 16'hA000);
    a_out_pop = 1'b1;
    a_wait(2);
    for (int i = 1; i < 9; i++) begin
      @(negedge clock);
      chk("drain_empty_flag", a_out_empty, 0);
      chk("drain_word", a_out_data, 32'hA000 + i);
      a_out_pop = 1'b1;
    end
    @(negedge clock);
    a_out_pop = 1'b0;
    chk("drain_out_empty", a_out_empty, 1);

    // Two strobes together: illegal, no FIFO side effect.
    a_start(4'b1001, 16'd5, 16'h9999, 16'h0000, 1'b1, 4); a_wait(8);
    @(negedge clock);
    chk("multi_strobe_out_empty", a_out_empty, 1);

    // Reset in the middle of a write's wait states.
    @(negedge clock);
    {a_mr, a_mw, a_ir, a_iw} = 4'b0100;
    a_addr = 16'd3;
    a_wdata = 16'h1234;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    {a_mr, a_mw, a_ir, a_iw} = 4'b0000;
    @(negedge clock);
    chk("midreset_ready", a_ready, 0);
    chk("midreset_err", a_err, 0);
    chk("midreset_out_empty", a_out_empty, 1);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    a_start(4'b1000, 16'd3, 16'h0000, 16'h5555, 1'b0, 4); a_wait(8);

    // LATENCY=0 instance: out-of-range accesses leave mem[0] alone.
    b_acc(4'b0100, 16'd0, 16'h7777, 16'h0000, 1'b0);
    b_acc(4'b1000, 16'd1024, 16'h0000, 16'h0000, 1'b1);
    b_acc(4'b0100, 16'd1024, 16'hDEAD, 16'h0000, 1'b1);
    b_acc(4'b1000, 16'd0, 16'h0000, 16'h7777, 1'b0);
    chk("b_out_empty", b_out_empty, 1);

    repeat (3) @(negedge clock);
    chk("a_scoreboard_empty", 32'(aq.size()), 0);
    chk("b_scoreboard_empty", 32'(bq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
